// File: rtl/ota_cmp_decimator.sv
// ota_cmp_decimator
// Synchronises and deglitches the OTA comparator level, then measures its
// high-density over back-to-back windows of 2^WIN_LOG2 clocks.
// Optional build macro: OTA_DECIM_TOGGLE_CNT_EN adds a per-window count of
// filtered-level transitions on toggle_cnt (tied to zero otherwise).
module ota_cmp_decimator #(
  parameter int SYNC_STAGES = 2,
  parameter int DEGLITCH    = 3,
  parameter int WIN_LOG2    = 8,
  parameter int OUT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             cmp_in,
  output logic             cmp_level,
  output logic [OUT_W-1:0] result,
  output logic             result_valid,
  output logic             busy,
  output logic [7:0]       toggle_cnt
);

  localparam int HI_W     = WIN_LOG2 + 1;
  localparam int SHIFT    = WIN_LOG2 - OUT_W;
  localparam int SETTLE_N = SYNC_STAGES + DEGLITCH;

  localparam logic [3:0]          DG_LAST     = 4'(DEGLITCH - 1);
  localparam logic [4:0]          SETTLE_LAST = 5'(SETTLE_N - 1);
  localparam logic [WIN_LOG2-1:0] WIN_ZERO    = {WIN_LOG2{1'b0}};
  localparam logic [WIN_LOG2-1:0] WIN_ONE     = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [HI_W-1:0]     HI_ZERO     = {HI_W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2
  } state_t;

  // A full window (all samples high) overflows the code range and saturates.
  function automatic logic [OUT_W-1:0] density_code(input logic [HI_W-1:0] hi);
    logic [OUT_W-1:0] code;
    if (hi[HI_W-1]) begin
      code = {OUT_W{1'b1}};
    end else begin
      code = OUT_W'(hi >> SHIFT);
    end
    return code;
  endfunction

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  logic [3:0]             dg_cnt_q, dg_cnt_d;
  logic                   level_q, level_d;

  state_t                 state_q, state_d;
  logic [4:0]             settle_q, settle_d;
  logic [WIN_LOG2-1:0]    win_q, win_d;
  logic [HI_W-1:0]        hi_q, hi_d;
  logic [HI_W-1:0]        hi_sum_s;
  logic                   close_s;

  logic [OUT_W-1:0]       result_q;
  logic                   valid_q;
  logic                   busy_q;

  assign sync_s   = sync_q[SYNC_STAGES-1];
  assign hi_sum_s = hi_q + HI_W'(level_q);

  // Shift the asynchronous comparator level through the synchroniser chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmp_in};
    end
  end

  // Deglitch: flip the filtered level after DEGLITCH consecutive disagreeing samples.
  always_comb begin
    dg_cnt_d = dg_cnt_q;
    level_d  = level_q;
    if (sync_s != level_q) begin
      if (dg_cnt_q == DG_LAST) begin
        level_d  = ~level_q;
        dg_cnt_d = 4'd0;
      end else begin
        dg_cnt_d = dg_cnt_q + 4'd1;
      end
    end else begin
      dg_cnt_d = 4'd0;
    end
  end

  // Deglitch counter and filtered level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dg_cnt_q <= 4'd0;
      level_q  <= 1'b0;
    end else begin
      dg_cnt_q <= dg_cnt_d;
      level_q  <= level_d;
    end
  end

  // Next-state logic: settle timer, window counters and close detection.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    win_d    = win_q;
    hi_d     = hi_q;
    close_s  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en) begin
          state_d  = ST_SETTLE;
          settle_d = 5'd0;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_SETTLE: begin
        if (clr) begin
          settle_d = 5'd0;
        end else if (!en) begin
          state_d  = ST_IDLE;
          settle_d = 5'd0;
        end else if (settle_q == SETTLE_LAST) begin
          state_d  = ST_RUN;
          settle_d = 5'd0;
          win_d    = WIN_ZERO;
          hi_d     = HI_ZERO;
        end else begin
          settle_d = settle_q + 5'd1;
        end
      end
      ST_RUN: begin
        if (clr) begin
          state_d  = ST_SETTLE;
          settle_d = 5'd0;
          win_d    = WIN_ZERO;
          hi_d     = HI_ZERO;
        end else if (!en) begin
          state_d  = ST_IDLE;
          win_d    = WIN_ZERO;
          hi_d     = HI_ZERO;
        end else if (&win_q) begin
          // Last sample of the window is folded into hi_sum_s; restart with no gap.
          close_s  = 1'b1;
          win_d    = WIN_ZERO;
          hi_d     = HI_ZERO;
        end else begin
          win_d    = win_q + WIN_ONE;
          hi_d     = hi_sum_s;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        settle_d = 5'd0;
        win_d    = WIN_ZERO;
        hi_d     = HI_ZERO;
      end
    endcase
  end

  // State and window counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      settle_q <= 5'd0;
      win_q    <= WIN_ZERO;
      hi_q     <= HI_ZERO;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      win_q    <= win_d;
      hi_q     <= hi_d;
    end
  end

  // Registered outputs: result latched on window close, one-cycle valid strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_q <= {OUT_W{1'b0}};
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      result_q <= close_s ? density_code(hi_sum_s) : result_q;
      valid_q  <= close_s;
      busy_q   <= (state_d != ST_IDLE);
    end
  end

  assign cmp_level    = level_q;
  assign result       = result_q;
  assign result_valid = valid_q;
  assign busy         = busy_q;

`ifdef OTA_DECIM_TOGGLE_CNT_EN
  logic       run_ok_s;
  logic       flip_s;
  logic [7:0] tog_q, tog_d, tog_sum_s, tog_out_q;

  assign run_ok_s  = (state_q == ST_RUN) && en && !clr;
  assign flip_s    = level_d ^ level_q;
  assign tog_sum_s = (tog_q == 8'hFF) ? 8'hFF : (tog_q + {7'd0, flip_s});

  // Toggle accumulator: counts filtered flips inside an uninterrupted window.
  always_comb begin
    tog_d = 8'd0;
    if (run_ok_s) begin
      if (close_s) begin
        tog_d = 8'd0;
      end else begin
        tog_d = tog_sum_s;
      end
    end else begin
      tog_d = 8'd0;
    end
  end

  // Toggle accumulator and its latched copy, updated alongside result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tog_q     <= 8'd0;
      tog_out_q <= 8'd0;
    end else begin
      tog_q     <= tog_d;
      tog_out_q <= close_s ? tog_sum_s : tog_out_q;
    end
  end

  assign toggle_cnt = tog_out_q;
`else
  assign toggle_cnt = 8'd0;
`endif

endmodule
